axis_dsm_decimator: RTL and testbench

//  Receive-side counterpart of the TX modulator chain: converts a 1-bit delta-sigma bitstream
//  (loopback of a DSM DAC output, or an external 1-bit ADC) back into WIDTH-bit signed samples.

---
 rtl/axis_dsm_decimator.sv | 157 +++++++++++++++
 tb/tb_axis_dsm_decimator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dsm_decimator.sv
// Third-order CIC decimator turning a 1-bit delta-sigma stream into WIDTH-bit signed samples.
// Optional build macro DSM_DECIM_STATS_EN adds the frame_count handoff counter port.
module axis_dsm_decimator #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DECIM_LOG2 = 5
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [WIDTH-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready
`ifdef DSM_DECIM_STATS_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int unsigned ACC_W = 2 + 3 * DECIM_LOG2;
    localparam int unsigned CNT_W = DECIM_LOG2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [ACC_W-1:0] samp_q, samp_d, samp_prev_q, samp_prev_d;
    logic [ACC_W-1:0] c1_q, c1_d, c1_prev_q, c1_prev_d;
    logic [ACC_W-1:0] c2_q, c2_d, c2_prev_q, c2_prev_d;
    logic [ACC_W-1:0] c3, beat_x;
    logic             v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             frame_end, pending, s_ready, accept;

    // Integrators advance only on accepted beats; combs advance unconditionally because
    // the closing beat is held off until the whole pipeline and output register are free.
    always_comb begin
        beat_x      = s_axis_data_tdata ? ACC_W'(1) : {ACC_W{1'b1}};
        frame_end   = &cnt_q;
        pending     = v0_q | v1_q | v2_q | (tvalid_q & ~m_axis_data_tready);
        s_ready     = ~(frame_end & pending);
        accept      = s_axis_data_tvalid & s_ready;
        c3          = c2_q - c2_prev_q;

        cnt_d       = cnt_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        samp_d      = samp_q;
        samp_prev_d = samp_prev_q;
        c1_d        = c1_q;
        c1_prev_d   = c1_prev_q;
        c2_d        = c2_q;
        c2_prev_d   = c2_prev_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        v0_d        = accept & frame_end;
        v1_d        = v0_q;
        v2_d        = v1_q;

        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            i1_d  = i1_q + beat_x;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
        end
        if (accept && frame_end) begin
            samp_d = i3_q;
        end
        if (v0_q) begin
            c1_d        = samp_q - samp_prev_q;
            samp_prev_d = samp_q;
        end
        if (v1_q) begin
            c2_d      = c1_q - c1_prev_q;
            c1_prev_d = c1_q;
        end
        // Top WIDTH bits of comb3 equal an arithmetic right shift by ACC_W-WIDTH.
        if (v2_q) begin
            tdata_d   = c3[ACC_W-1 -: WIDTH];
            tvalid_d  = 1'b1;
            c2_prev_d = c2_q;
        end else if (m_axis_data_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            cnt_q       <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            samp_q      <= '0;
            samp_prev_q <= '0;
            c1_q        <= '0;
            c1_prev_q   <= '0;
            c2_q        <= '0;
            c2_prev_q   <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            samp_q      <= samp_d;
            samp_prev_q <= samp_prev_d;
            c1_q        <= c1_d;
            c1_prev_q   <= c1_prev_d;
            c2_q        <= c2_d;
            c2_prev_q   <= c2_prev_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
        end
    end

    // Fractional bits dropped by the output scaling.
    generate
        if (ACC_W > WIDTH) begin : g_lsb
            logic unused_lsbs;
            assign unused_lsbs = ^c3[ACC_W-WIDTH-1:0];
        end
    endgenerate

    assign s_axis_data_tready = s_ready;
    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;

`ifdef DSM_DECIM_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (tvalid_q && m_axis_data_tready) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_axis_dsm_decimator.sv
// Scoreboard bench for axis_dsm_decimator; the reference model computes each output from
// binomial-weighted beat sums differenced across frames.
module tb_axis_dsm_decimator;

    localparam int R = 32;

    logic        aclk;
    logic        rst;
    logic        s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
`ifdef DSM_DECIM_STATS_EN
    logic [15:0] frame_count;
`endif

    axis_dsm_decimator #(.WIDTH(16), .DECIM_LOG2(5)) dut (
        .aclk               (aclk),
        .rst                (rst),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready)
`ifdef DSM_DECIM_STATS_EN
        ,
        .frame_count        (frame_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] exp;
        bit          settled;
        bit          chk_const;
        logic [15:0] cval;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          beats[$];
    longint      wl[$];
    exp_t        sb[$];
    int          lat[$];
    int          cyc = 0;
    int          n_out = 0;
    int          k = 0;
    bit          const_en = 1'b0;
    logic [15:0] const_val = '0;
    logic        prev_tvalid = 1'b0;
    logic        prev_tready = 1'b1;
    logic [15:0] prev_tdata = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Integrator-3 contents after beat m: each beat weighted by C(m-k, 2).
    function automatic longint w_of(input int m);
        longint s = 0;
        for (int j = 0; j <= m; j++) begin
            longint d = longint'(m - j);
            s += longint'(beats[j]) * ((d * (d - 1)) / 2);
        end
        return s;
    endfunction

    function automatic longint w_at(input int idx);
        return (idx < 0) ? 64'sd0 : wl[idx];
    endfunction

    function automatic logic pat(input int mode, input int idx);
        int lvl;
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return (idx % 2) == 0;
            3: return (idx % 4) != 3;
            4: return 1'($urandom_range(0, 1));
            default: begin
                lvl = (idx / 32) % 65;
                return (((idx + 1) * lvl) / 64) != ((idx * lvl) / 64);
            end
        endcase
    endfunction

    // Monitor: model update on accepted beats, scoreboard pop on output handshakes.
    always @(negedge aclk) begin
        cyc++;
        if (rst) begin
            beats.delete();
            wl.delete();
            sb.delete();
            lat.delete();
            n_out       = 0;
            prev_tvalid = 1'b0;
            prev_tready = 1'b1;
            prev_tdata  = '0;
        end else begin
            if (!s_tready) begin
                check("stall_only_at_cnt31", 32'(beats.size() % R), 32'(R - 1));
            end
            if (m_tready) begin
                check("s_ready_while_m_ready", 32'(s_tready), 32'd1);
            end
            if (s_tvalid && s_tready) begin
                beats.push_back(s_tdata ? 1 : -1);
                if ((beats.size() % R) == 0) begin
                    exp_t   e;
                    longint y;
                    int     nw;
                    // Sample register captures integrator 3 as it stood before the closing beat.
                    wl.push_back(w_of(beats.size() - 2));
                    nw = wl.size();
                    y = w_at(nw - 1) - 3 * w_at(nw - 2) + 3 * w_at(nw - 3) - w_at(nw - 4);
                    e.exp       = 16'(y >>> 1);
                    e.settled   = (nw >= 4);
                    e.chk_const = const_en;
                    e.cval      = const_val;
                    sb.push_back(e);
                    lat.push_back(cyc + 4);
                end
            end
            if (m_tvalid && !prev_tvalid) begin
                if (lat.size() == 0) begin
                    check("latency_unexpected_valid", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    check("latency", 32'(cyc), 32'(lat.pop_front()));
                end
            end
            if (prev_tvalid && !prev_tready) begin
                check("hold_tvalid", 32'(m_tvalid), 32'd1);
                check("hold_tdata", 32'(m_tdata), 32'(prev_tdata));
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("output_unexpected", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.settled) begin
                        check("sample", 32'(m_tdata), 32'(e.exp));
                        if (e.chk_const) begin
                            check("sample_const", 32'(m_tdata), 32'(e.cval));
                        end
                    end
                end
                n_out++;
            end
            prev_tvalid = m_tvalid;
            prev_tready = m_tready;
            prev_tdata  = m_tdata;
        end
    end

    // Drives beats until n have been accepted; optional window with m_tready held low.
    task automatic run(input int n, input int mode, input int vpct, input int rpct,
                       input int hold_start, input int hold_len);
        int got    = 0;
        int cyc_l  = 0;
        int budget = n * 4 + hold_len + 500;
        bit acc;
        while (got < n) begin
            if (cyc_l > budget) begin
                check("run_timeout", 32'(got), 32'(n));
                break;
            end
            s_tvalid = ($urandom_range(0, 99) < vpct);
            s_tdata  = pat(mode, k);
            if (hold_len > 0 && cyc_l >= hold_start && cyc_l < hold_start + hold_len) begin
                m_tready = 1'b0;
            end else begin
                m_tready = ($urandom_range(0, 99) < rpct);
            end
            @(negedge aclk);
            acc = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (acc) begin
                k++;
                got++;
            end
            cyc_l++;
        end
    endtask

    task automatic do_reset(input int ncyc);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        rst      = 1'b1;
        repeat (ncyc) @(posedge aclk);
        #1;
        rst = 1'b0;
        k   = 0;
        @(negedge aclk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
`ifdef DSM_DECIM_STATS_EN
        check("rst_frame_count", 32'(frame_count), 32'd0);
`endif
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (20) @(posedge aclk);
        #1;
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("out_count", 32'(n_out), 32'(beats.size() / R));
`ifdef DSM_DECIM_STATS_EN
        check("frame_count", 32'(frame_count), 32'(n_out % 65536));
`endif
    endtask

    task automatic const_phase(input int mode, input logic [15:0] cv, input int vpct);
        do_reset(1);
        const_en  = 1'b1;
        const_val = cv;
        run(9 * R, mode, vpct, 100, 0, 0);
        drain();
        const_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        do_reset(3);

        const_phase(0, 16'h4000, 100);
        const_phase(1, 16'hC000, 100);
        const_phase(2, 16'h0000, 100);
        const_phase(3, 16'h2000, 100);
        const_phase(0, 16'h4000, 50);

        do_reset(1);
        run(10 * R, 4, 80, 70, 0, 0);
        drain();

        do_reset(1);
        run(14 * R, 5, 100, 100, 150, 200);
        drain();

        do_reset(1);
        run(4 * R + 10, 4, 100, 100, 0, 0);
        do_reset(1);
        run(6 * R, 4, 100, 100, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
